tri_raster_queue: RTL and testbench

//  Parametrised wireframe rasterizer with an input triangle queue and an optional screen-clear pass.
//  - Accepts Triangle3D + Color over a valid/ready handshake into a FIFO.
//  - Projects each triangle orthographically (x, y kept; z dropped).
//  - Walks edges AB, BC, CA with Bresenham and emits one pixel write per cycle.
//  - Sits between the geometry front end and the wireframe frame-buffer RAM.

---
 rtl/tri_raster_queue_pkg.sv | 65 ++++++
 rtl/tri_raster_queue_line_walker.sv | 85 ++++++++
 rtl/tri_raster_queue.sv | 192 +++++++++++++++++++
 tb/tb_tri_raster_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_raster_queue_pkg.sv
// Shared geometry/colour types, raster FSM states and the orthographic projection helper.
package tri_raster_queue_pkg;

  localparam int RASTER_COORD_W = 8;

  typedef logic [RASTER_COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } Point2D;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } Point3D;

  typedef struct packed {
    Point2D a;
    Point2D b;
    Point2D c;
  } Triangle2D;

  typedef struct packed {
    Point3D a;
    Point3D b;
    Point3D c;
  } Triangle3D;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

  typedef struct packed {
    Triangle3D geom;
    Color      col;
  } tri_entry_t;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_CLEAR,
    RS_LOAD,
    RS_EDGE,
    RS_DONE
  } RasterState_t;

  function automatic Point2D drop_z(input Point3D p);
    Point2D r;
    r.x = p.x;
    r.y = p.y;
    return r;
  endfunction

  function automatic Triangle2D project(input Triangle3D t);
    Triangle2D r;
    r.a = drop_z(t.a);
    r.b = drop_z(t.b);
    r.c = drop_z(t.c);
    return r;
  endfunction

endpackage

// File: rtl/tri_raster_queue_line_walker.sv
// Bresenham line walker: emits every point from p to q inclusive, one per cycle, all octants.
// Latency: first point one cycle after start; done marks the cycle carrying q. No backpressure.
module tri_raster_queue_line_walker
  import tri_raster_queue_pkg::*;
(
  input  logic   clk,
  input  logic   n_rst,
  input  logic   start,
  input  Point2D p,
  input  Point2D q,
  output Point2D point,
  output logic   valid,
  output logic   done
);

  localparam int EW = RASTER_COORD_W + 2;

  Point2D               cur;
  Point2D               dst;
  logic signed [EW-1:0] dx_r;
  logic signed [EW-1:0] dy_r;
  logic signed [EW-1:0] err_r;
  logic signed [EW-1:0] err_nxt;
  logic signed [EW-1:0] dx_init;
  logic signed [EW-1:0] dy_init;
  logic signed [EW:0]   e2;
  logic signed [EW:0]   dx_ext;
  logic signed [EW:0]   dy_ext;
  coord_t               abs_x;
  coord_t               abs_y;
  logic                 sx_neg;
  logic                 sy_neg;
  logic                 step_x;
  logic                 step_y;

  always_comb begin
    abs_x   = (q.x >= p.x) ? q.x - p.x : p.x - q.x;
    abs_y   = (q.y >= p.y) ? q.y - p.y : p.y - q.y;
    dx_init = $signed({2'b00, abs_x});
    dy_init = -$signed({2'b00, abs_y});
    // dy is kept negative so one error term covers shallow and steep lines alike
    e2      = {err_r, 1'b0};
    dx_ext  = {dx_r[EW-1], dx_r};
    dy_ext  = {dy_r[EW-1], dy_r};
    step_x  = (e2 >= dy_ext);
    step_y  = (e2 <= dx_ext);
    err_nxt = err_r;
    if (step_x) err_nxt = err_nxt + dy_r;
    if (step_y) err_nxt = err_nxt + dx_r;
  end

  assign point = cur;
  assign done  = valid && (cur == dst);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cur    <= '0;
      dst    <= '0;
      dx_r   <= '0;
      dy_r   <= '0;
      err_r  <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      valid  <= 1'b0;
    end else if (start) begin
      cur    <= p;
      dst    <= q;
      dx_r   <= dx_init;
      dy_r   <= dy_init;
      err_r  <= dx_init + dy_init;
      sx_neg <= (q.x < p.x);
      sy_neg <= (q.y < p.y);
      valid  <= 1'b1;
    end else if (valid) begin
      if (done) begin
        valid <= 1'b0;
      end else begin
        if (step_x) cur.x <= sx_neg ? cur.x - 1'b1 : cur.x + 1'b1;
        if (step_y) cur.y <= sy_neg ? cur.y - 1'b1 : cur.y + 1'b1;
        err_r <= err_nxt;
      end
    end
  end

endmodule

// File: rtl/tri_raster_queue.sv
// Wireframe rasterizer with triangle queue and screen clear; RASTER_CLIP_EN suppresses off-screen writes.
// Latency: first pixel 2 cycles after LOAD; per triangle sum(max(|dx|,|dy|)+1) + 3 restart cycles.
// Backpressure: tri_ready drops while the queue is full; pixel output has no stall.
module tri_raster_queue
  import tri_raster_queue_pkg::*;
#(
  parameter int SCREEN_W   = 64,
  parameter int SCREEN_H   = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(SCREEN_W * SCREEN_H),
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              tri_valid,
  output logic              tri_ready,
  input  Triangle3D         tri_in,
  input  Color              color_in,
  input  logic              clear_req,
  output logic              px_we,
  output logic [ADDR_W-1:0] px_addr,
  output logic              px_data,
  output Color              px_color,
  output logic              busy,
  output logic              tri_done,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PIX_N  = SCREEN_W * SCREEN_H;
  localparam int WIDE_W = ADDR_W + RASTER_COORD_W;

  tri_entry_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  tri_entry_t         head;

  RasterState_t       state;
  RasterState_t       state_nxt;
  Triangle2D          cur_tri;
  Color               cur_color;
  logic [1:0]         edge_idx;
  logic               launch;
  logic               clear_pend;
  logic               go_clear;
  logic [ADDR_W-1:0]  clr_addr;
  logic               clr_last;

  logic               wk_start;
  Point2D             wk_p;
  Point2D             wk_q;
  Point2D             wk_pt;
  logic               wk_valid;
  logic               wk_done;
  logic [ADDR_W-1:0]  pix_addr;
  logic               in_range;

  // Ready comes from the registered count, so a pop in the same cycle never opens it.
  assign tri_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign push       = tri_valid && tri_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != RS_IDLE) || (count != '0);
  assign go_clear   = clear_pend || clear_req;
  assign clr_last   = (clr_addr == ADDR_W'(PIX_N - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tri_in, color_in};
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    case (edge_idx)
      2'd0:    begin wk_p = cur_tri.a; wk_q = cur_tri.b; end
      2'd1:    begin wk_p = cur_tri.b; wk_q = cur_tri.c; end
      default: begin wk_p = cur_tri.c; wk_q = cur_tri.a; end
    endcase
  end

  tri_raster_queue_line_walker u_walker (
    .clk   (clk),
    .n_rst (n_rst),
    .start (wk_start),
    .p     (wk_p),
    .q     (wk_q),
    .point (wk_pt),
    .valid (wk_valid),
    .done  (wk_done)
  );

  assign pix_addr = ADDR_W'(WIDE_W'(wk_pt.y) * WIDE_W'(SCREEN_W) + WIDE_W'(wk_pt.x));

`ifdef RASTER_CLIP_EN
  assign in_range = ({1'b0, wk_pt.x} < (RASTER_COORD_W + 1)'(SCREEN_W)) &&
                    ({1'b0, wk_pt.y} < (RASTER_COORD_W + 1)'(SCREEN_H));
`else
  assign in_range = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) state <= RS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wk_start  = 1'b0;
    px_we     = 1'b0;
    px_data   = 1'b0;
    px_addr   = '0;
    px_color  = '0;
    tri_done  = 1'b0;
    case (state)
      RS_IDLE: begin
        if (go_clear)          state_nxt = RS_CLEAR;
        else if (count != '0)  state_nxt = RS_LOAD;
      end
      RS_CLEAR: begin
        px_we   = 1'b1;
        px_addr = clr_addr;
        if (clr_last) state_nxt = RS_IDLE;
      end
      RS_LOAD: begin
        pop       = 1'b1;
        state_nxt = RS_EDGE;
      end
      RS_EDGE: begin
        wk_start = launch;
        px_we    = wk_valid && in_range;
        px_data  = wk_valid && in_range;
        px_addr  = pix_addr;
        px_color = cur_color;
        if (wk_done && edge_idx == 2'd2) state_nxt = RS_DONE;
      end
      RS_DONE: begin
        tri_done  = 1'b1;
        state_nxt = RS_IDLE;
      end
      default: state_nxt = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cur_tri    <= '0;
      cur_color  <= '0;
      edge_idx   <= '0;
      launch     <= 1'b0;
      clear_pend <= 1'b0;
      clr_addr   <= '0;
    end else begin
      if (state == RS_IDLE && go_clear) clear_pend <= 1'b0;
      else if (clear_req)               clear_pend <= 1'b1;

      if (state == RS_CLEAR) clr_addr <= clr_last ? '0 : clr_addr + 1'b1;

      if (pop) begin
        cur_tri   <= project(head.geom);
        cur_color <= head.col;
        edge_idx  <= '0;
        launch    <= 1'b1;
      end else if (state == RS_EDGE) begin
        // Each edge costs one start cycle before its first point.
        if (launch) launch <= 1'b0;
        if (wk_done && edge_idx != 2'd2) begin
          edge_idx <= edge_idx + 1'b1;
          launch   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tri_raster_queue.sv
// Directed bench for tri_raster_queue: outline, degenerate, clear, queue-full, clip and reset-abort cases.
module tb_tri_raster_queue;
  import tri_raster_queue_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        tri_valid = 1'b0;
  logic        clear_req = 1'b0;
  Triangle3D   tri_in;
  Color        color_in;
  logic        tri_ready;
  logic        px_we;
  logic [11:0] px_addr;
  logic        px_data;
  Color        px_color;
  logic        busy;
  logic        tri_done;
  logic [2:0]  fifo_count;

  tri_raster_queue dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .tri_in     (tri_in),
    .color_in   (color_in),
    .clear_req  (clear_req),
    .px_we      (px_we),
    .px_addr    (px_addr),
    .px_data    (px_data),
    .px_color   (px_color),
    .busy       (busy),
    .tri_done   (tri_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int  cyc = 0;
  int  we_total = 0;
  int  done_total = 0;
  int  cnt_max = 0;
  int  ready_viol = 0;
  bit  saw_full = 1'b0;
  int  log_addr [16384];
  bit  log_data [16384];
  int  log_col  [16384];
  int  log_cyc  [16384];
  int  done_log [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (px_we === 1'b1) begin
      if (we_total < 16384) begin
        log_addr[we_total] <= int'(px_addr);
        log_data[we_total] <= px_data;
        log_col[we_total]  <= int'(px_color);
        log_cyc[we_total]  <= cyc;
      end
      we_total <= we_total + 1;
    end
    if (tri_done === 1'b1) begin
      if (done_total < 64) done_log[done_total] <= cyc;
      done_total <= done_total + 1;
    end
    if (n_rst === 1'b1) begin
      if (int'(fifo_count) > cnt_max) cnt_max <= int'(fifo_count);
      if (tri_ready !== (fifo_count != 3'd4)) ready_viol <= ready_viol + 1;
      if (fifo_count == 3'd4 && tri_ready === 1'b0) saw_full <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_tri(input logic [7:0] ax, input logic [7:0] ay, input logic [7:0] bx,
                          input logic [7:0] by, input logic [7:0] cx, input logic [7:0] cy,
                          input logic [23:0] col, output int acc_cyc, output int cnt_before);
    int w;
    @(negedge clk);
    tri_in.a.x = ax; tri_in.a.y = ay; tri_in.a.z = ax ^ 8'h5a;
    tri_in.b.x = bx; tri_in.b.y = by; tri_in.b.z = by ^ 8'ha5;
    tri_in.c.x = cx; tri_in.c.y = cy; tri_in.c.z = 8'hff;
    color_in   = col;
    tri_valid  = 1'b1;
    w = 0;
    while (tri_ready !== 1'b1 && w < 6000) begin
      @(negedge clk);
      w++;
    end
    check("push_accept", (w < 6000), 1);
    cnt_before = int'(fifo_count);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    tri_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int limit, input string tag);
    int w = 0;
    while (done_total < n && w < limit) begin
      @(posedge clk);
      w++;
    end
    check(tag, (done_total >= n), 1);
  endtask

  task automatic wait_we(input int n, input int limit, input string tag);
    int w = 0;
    while (we_total < n && w < limit) begin
      @(posedge clk);
      w++;
    end
    check(tag, (we_total >= n), 1);
  endtask

  initial begin
    int acc, cb, acc2, cb2, b, bd, bad, mx, ws, ds;
    int acc_k [5];
    int cb_k  [5];
    int exp1  [12];
    exp1 = '{0, 1, 2, 3, 3, 66, 129, 192, 192, 128, 64, 0};
    tri_in   = '0;
    color_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_px_we", px_we, 0);
    check("rst_tri_ready", tri_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_tri_done", tri_done, 0);
    check("rst_px_addr", px_addr, 0);
    check("rst_px_data", px_data, 0);
    check("rst_px_color", px_color, 0);
    n_rst = 1'b1;

    // Right triangle outline (0,0)(3,0)(0,3)
    b = we_total; bd = done_total;
    push_tri(8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd3, 24'h112233, acc, cb);
    wait_done(bd + 1, 200, "t1_done_seen");
    repeat (2) @(posedge clk);
    check("t1_writes", we_total - b, 12);
    bad = 0;
    for (int i = 0; i < 12; i++)
      if (log_addr[b+i] != exp1[i] || log_data[b+i] != 1'b1 || log_col[b+i] != 32'h112233) bad++;
    check("t1_pixels", bad, 0);
    check("t1_first_addr", log_addr[b], 0);
    check("t1_last_addr", log_addr[b+11], 0);
    check("t1_first_latency", log_cyc[b] - acc, 3);
    check("t1_done_after_last", done_log[bd] - log_cyc[b+11], 1);
    check("t1_total_cycles", done_log[bd] - acc, 17);
    check("t1_done_pulses", done_total - bd, 1);
    @(negedge clk);
    check("t1_idle_busy", busy, 0);

    // Fully degenerate triangle at (5,5)
    b = we_total; bd = done_total;
    push_tri(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 24'h0a0b0c, acc, cb);
    wait_done(bd + 1, 100, "t4_done_seen");
    repeat (2) @(posedge clk);
    check("t4_writes", we_total - b, 3);
    bad = 0;
    for (int i = 0; i < 3; i++) if (log_addr[b+i] != 325 || log_data[b+i] != 1'b1) bad++;
    check("t4_addr_325", bad, 0);
    check("t4_done_after_last", done_log[bd] - log_cyc[b+2], 1);
    check("t4_total_cycles", done_log[bd] - acc, 8);

    // Clear requested mid-triangle, with a second triangle queued behind it
    b = we_total; bd = done_total;
    push_tri(8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd3, 24'h223344, acc, cb);
    wait_we(b + 1, 50, "t3_first_write");
    push_tri(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 24'h445566, acc2, cb2);
    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    @(posedge clk);
    check("t3_tri_in_flight", done_total - bd, 0);
    wait_done(bd + 2, 5000, "t3_done_seen");
    repeat (2) @(posedge clk);
    check("t3_writes", we_total - b, 12 + 4096 + 3);
    bad = 0;
    for (int i = 0; i < 12; i++)
      if (log_addr[b+i] != exp1[i] || log_data[b+i] != 1'b1 || log_col[b+i] != 32'h223344) bad++;
    check("t3_tri_complete", bad, 0);
    check("t3_clear_after_done", (log_cyc[b+12] > done_log[bd]), 1);
    bad = 0;
    for (int i = 0; i < 4096; i++)
      if (log_addr[b+12+i] != i || log_data[b+12+i] != 1'b0 || log_col[b+12+i] != 0) bad++;
    check("t3_clear_sweep", bad, 0);
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (log_addr[b+4108+i] != 65 || log_data[b+4108+i] != 1'b1 || log_col[b+4108+i] != 32'h445566) bad++;
    check("t3_next_tri", bad, 0);

    // Five triangles offered while a clear holds the queue
    b = we_total; bd = done_total;
    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    for (int k = 0; k < 5; k++)
      push_tri(8'(k), 8'd2, 8'(k), 8'd2, 8'(k), 8'd2, 24'h000100 + 24'(k), acc_k[k], cb_k[k]);
    for (int k = 0; k < 5; k++)
      check($sformatf("t2_count_before_push%0d", k), cb_k[k], (k < 4) ? k : 3);
    check("t2_saw_full_not_ready", saw_full, 1);
    wait_done(bd + 5, 500, "t2_done_seen");
    repeat (2) @(posedge clk);
    check("t2_writes", we_total - b, 4096 + 15);
    check("t2_four_during_clear", (acc_k[3] < log_cyc[b+4095]), 1);
    check("t2_fifth_after_pop", (acc_k[4] > log_cyc[b+4095]), 1);
    bad = 0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 3; j++)
        if (log_addr[b+4096+3*k+j] != 128 + k || log_col[b+4096+3*k+j] != 32'h100 + k) bad++;
    check("t2_queue_order", bad, 0);
    check("t2_fifo_count_max", cnt_max, 4);
    check("t2_ready_tracks_count", ready_viol, 0);

    // Edge leaving the screen: (60,0)->(70,0)->(60,0)
    b = we_total; bd = done_total;
    push_tri(8'd60, 8'd0, 8'd70, 8'd0, 8'd60, 8'd0, 24'h00ff00, acc, cb);
    wait_done(bd + 1, 200, "t5_done_seen");
    repeat (2) @(posedge clk);
    mx = 0;
    for (int i = 0; i < we_total - b; i++) if (log_addr[b+i] > mx) mx = log_addr[b+i];
`ifdef RASTER_CLIP_EN
    check("t5_writes", we_total - b, 9);
    check("t5_max_addr", mx, 63);
`else
    check("t5_writes", we_total - b, 23);
    check("t5_max_addr", mx, 70);
`endif
    check("t5_first_addr", log_addr[b], 60);
    check("t5_total_cycles", done_log[bd] - acc, 28);

    // Reset asserted in the middle of an edge
    b = we_total; bd = done_total;
    push_tri(8'd0, 8'd0, 8'd40, 8'd0, 8'd0, 8'd0, 24'h777777, acc, cb);
    push_tri(8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 24'h888888, acc2, cb2);
    wait_we(b + 1, 50, "t6_first_write");
    repeat (3) @(negedge clk);
    check("t6_mid_edge_we", px_we, 1);
    check("t6_count_before_rst", fifo_count, 1);
    n_rst = 1'b0;
    @(negedge clk);
    check("t6_rst_px_we", px_we, 0);
    check("t6_rst_fifo_count", fifo_count, 0);
    check("t6_rst_tri_done", tri_done, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_tri_ready", tri_ready, 1);
    @(posedge clk);
    ws = we_total; ds = done_total;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (60) @(posedge clk);
    check("t6_no_writes_after_rst", we_total, ws);
    check("t6_no_done_after_rst", done_total, ds);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
